// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MCB read/write port among NUM_REQ single-word requesters.
// Each grant is walked through write-FIFO push, command push and completion wait, then req_done pulses.
module mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*30-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_mask,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic                  err,
  output logic                  mem_cmd_en,
  output logic [2:0]            mem_cmd_instr,
  output logic [5:0]            mem_cmd_bl,
  output logic [29:0]           mem_cmd_byte_addr,
  input  logic                  mem_cmd_full,
  output logic                  mem_wr_en,
  output logic [3:0]            mem_wr_mask,
  output logic [31:0]           mem_wr_data,
  input  logic                  mem_wr_full,
  input  logic                  mem_wr_empty,
  input  logic                  mem_wr_underrun,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_empty,
  input  logic                  mem_rd_overflow
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;
  localparam int MASK_W = 4;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int TMO_W  = 10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CMD,
    S_WR_WAIT,
    S_RD_CMD,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_last;
  logic                post_done;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                tmo_abort;
  logic [NUM_REQ-1:0]  elig;
  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  logic                grant;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;
  logic [MASK_W-1:0]   own_mask;

  // Round-robin pick: first eligible requester after rr_last, wrapping.
  // The requester just served is masked for one IDLE cycle while it drops req.
  always_comb begin
    int j;
    j       = 0;
    elig    = req;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (post_done) elig[owner] = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(rr_last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_vld && elig[IDX_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  assign grant   = (state == S_IDLE) && calib_done && gnt_vld;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt     = state;
    tmo_abort     = 1'b0;
    mem_cmd_en    = 1'b0;
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    mem_cmd_instr = 3'b000;
    case (state)
      S_IDLE: begin
        if (grant) state_nxt = req_we[gnt_idx] ? S_WR_DATA : S_RD_CMD;
      end
      S_WR_DATA: begin
        mem_wr_en = calib_done && !mem_wr_full;
        if (mem_wr_en) begin
          state_nxt = S_WR_CMD;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          tmo_abort = 1'b1;
        end
      end
      S_WR_CMD: begin
        mem_cmd_en = calib_done && !mem_cmd_full;
        if (mem_cmd_en) begin
          state_nxt = S_WR_WAIT;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          tmo_abort = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (mem_wr_empty) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          tmo_abort = 1'b1;
        end
      end
      S_RD_CMD: begin
        mem_cmd_instr = 3'b001;
        mem_cmd_en    = calib_done && !mem_cmd_full;
        if (mem_cmd_en) begin
          state_nxt = S_RD_WAIT;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          tmo_abort = 1'b1;
        end
      end
      S_RD_WAIT: begin
        mem_rd_en = calib_done && !mem_rd_empty;
        if (mem_rd_en) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
          tmo_abort = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
      post_done <= 1'b0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_nxt;
      post_done <= (state == S_DONE);
      if (state_nxt != state || state == S_IDLE || state == S_DONE) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_abort || mem_wr_underrun || mem_rd_overflow) err <= 1'b1;
      if (grant) begin
        owner   <= gnt_idx;
        rr_last <= gnt_idx;
      end
      if (mem_rd_en) rd_data <= mem_rd_data;
    end
  end

  // Request payload is captured at grant; the owner may change its inputs afterwards.
  always_ff @(posedge clk) begin
    if (grant) begin
      own_addr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] & WORD_ALIGN;
      own_wdata <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      own_mask  <= req_mask[int'(gnt_idx)*MASK_W +: MASK_W];
    end
  end

  always_comb begin
    req_done = '0;
    if (state == S_DONE) req_done[owner] = 1'b1;
  end

  assign busy              = (state != S_IDLE);
  assign mem_cmd_bl        = 6'd0;
  assign mem_cmd_byte_addr = (state == S_WR_CMD || state == S_RD_CMD) ? own_addr : '0;
  assign mem_wr_data       = (state == S_WR_DATA) ? own_wdata : '0;
  assign mem_wr_mask       = (state == S_WR_DATA) ? own_mask : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand sequences against a small MCB FIFO model,
// with a second instance (TIMEOUT=15) for the stuck-read abort.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int N = 3;

  typedef struct {
    int          idx;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rret;
    int          rlat;
    logic [2:0]  exp_instr;
    logic [29:0] exp_addr;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          idx;
    logic        we;
    logic [2:0]  instr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            calib_done = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*30-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_mask = '0;
  logic [N-1:0]    req_done;
  logic [31:0]     rd_data;
  logic            busy, err;
  logic            mem_cmd_en;
  logic [2:0]      mem_cmd_instr;
  logic [5:0]      mem_cmd_bl;
  logic [29:0]     mem_cmd_byte_addr;
  logic            mem_cmd_full = 1'b0;
  logic            mem_wr_en;
  logic [3:0]      mem_wr_mask;
  logic [31:0]     mem_wr_data;
  logic            mem_wr_full = 1'b0;
  logic            mem_wr_empty = 1'b1;
  logic            mem_wr_underrun = 1'b0;
  logic            mem_rd_en;
  logic [31:0]     mem_rd_data = 32'hBAD0BAD0;
  logic            mem_rd_empty = 1'b1;
  logic            mem_rd_overflow = 1'b0;

  logic [N-1:0]    t_req = '0;
  logic [N-1:0]    t_done;
  logic [31:0]     t_rd_data;
  logic            t_busy, t_err, t_cmd_en, t_wr_en, t_rd_en;
  logic [2:0]      t_instr;
  logic [5:0]      t_bl;
  logic [29:0]     t_addr;
  logic [3:0]      t_wr_mask;
  logic [31:0]     t_wr_data;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[6];

  logic        cap_cmd_en = 1'b0, cap_wr_en = 1'b0, cap_rd_en = 1'b0;
  logic [2:0]  cap_instr = 3'b000;
  int          wr_cnt = 0;
  int          rd_timer = 0;
  logic        rd_avail = 1'b0;
  logic [31:0] rd_ret = 32'h0;
  int          rd_lat = 1;
  logic        hold_wr_busy = 1'b0;

  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_done(req_done), .rd_data(rd_data), .busy(busy), .err(err),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
    .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty), .mem_wr_underrun(mem_wr_underrun),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty),
    .mem_rd_overflow(mem_rd_overflow)
  );

  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) u_tmo (
    .clk(clk), .rst_n(rst_n), .calib_done(1'b1),
    .req(t_req), .req_we(3'b000), .req_addr({(N*30){1'b0}}), .req_wdata({(N*32){1'b0}}),
    .req_mask({(N*4){1'b0}}),
    .req_done(t_done), .rd_data(t_rd_data), .busy(t_busy), .err(t_err),
    .mem_cmd_en(t_cmd_en), .mem_cmd_instr(t_instr), .mem_cmd_bl(t_bl),
    .mem_cmd_byte_addr(t_addr), .mem_cmd_full(1'b0),
    .mem_wr_en(t_wr_en), .mem_wr_mask(t_wr_mask), .mem_wr_data(t_wr_data),
    .mem_wr_full(1'b0), .mem_wr_empty(1'b1), .mem_wr_underrun(1'b0),
    .mem_rd_en(t_rd_en), .mem_rd_data(32'h5555AAAA), .mem_rd_empty(1'b1),
    .mem_rd_overflow(1'b0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; checks in the main flow happen there too.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // MCB model: observe pushes/pops mid-cycle, update FIFO status just after the edge.
  always @(negedge clk) begin
    cap_cmd_en = mem_cmd_en;
    cap_instr  = mem_cmd_instr;
    cap_wr_en  = mem_wr_en;
    cap_rd_en  = mem_rd_en;
  end

  always @(posedge clk) begin
    #1;
    if (cap_wr_en) wr_cnt = wr_cnt + 1;
    if (cap_cmd_en && cap_instr == 3'b000) wr_cnt = 0;
    if (cap_rd_en) rd_avail = 1'b0;
    if (cap_cmd_en && cap_instr == 3'b001) begin
      rd_timer = rd_lat;
    end else if (rd_timer > 0) begin
      rd_timer = rd_timer - 1;
      if (rd_timer == 0) rd_avail = 1'b1;
    end
    mem_wr_empty = (wr_cnt == 0) && !hold_wr_busy;
    mem_rd_empty = !rd_avail;
    mem_rd_data  = rd_avail ? rd_ret : 32'hBAD0BAD0;
    cap_cmd_en = 1'b0;
    cap_wr_en  = 1'b0;
    cap_rd_en  = 1'b0;
  end

  // Scoreboard: compare every push and every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_cmd_full) check("cmd_en_while_full", {31'd0, mem_cmd_en}, 32'd0);
      if (exp_q.size() > 0) begin
        if (mem_wr_en) begin
          check("wr_data", mem_wr_data, exp_q[0].wdata);
          check("wr_mask", 32'(mem_wr_mask), 32'(exp_q[0].mask));
        end
        if (mem_cmd_en) begin
          check("cmd_instr", 32'(mem_cmd_instr), 32'(exp_q[0].instr));
          check("cmd_addr", 32'(mem_cmd_byte_addr), 32'(exp_q[0].addr));
          check("cmd_bl", 32'(mem_cmd_bl), 32'd0);
        end
      end
      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got req_done=%b, required none", req_done);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_idx", 32'(req_done), 32'(1) << mon_e.idx);
          check("done_rd_data", rd_data, mon_e.rd);
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic we, input logic [29:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    req_we[idx]             = we;
    req_addr[idx*30 +: 30]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_mask[idx*4 +: 4]    = mask;
  endtask

  task automatic run_vec(input vec_t t);
    int n;
    exp_q.push_back('{t.idx, t.we, t.exp_instr, t.exp_addr, t.wdata, t.mask, t.exp_rd});
    set_req(t.idx, t.we, t.addr, t.wdata, t.mask);
    rd_ret = t.rret;
    rd_lat = t.rlat;
    req[t.idx] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!req_done[t.idx] && n < 200);
    if (!req_done[t.idx]) begin
      tests++;
      fails++;
      $display("FAIL vec_done_timeout: got no req_done[%0d] in %0d cycles, required one", t.idx, n);
    end else if (t.exp_lat != 0) begin
      check("vec_latency", 32'(n), 32'(t.exp_lat));
    end
    req[t.idx] = 1'b0;
    step();
    step();
  endtask

  initial begin
    int n;
    int dones;
    int busy_seen;
    tbl[0] = '{1, 1'b1, 30'h104,      32'hDEADBEEF, 4'h0,    32'h0,        0, 3'b000, 30'h104,      32'h0,        4};
    tbl[1] = '{0, 1'b0, 30'h107,      32'h0,        4'h0,    32'h12345678, 6, 3'b001, 30'h104,      32'h12345678, 0};
    tbl[2] = '{2, 1'b1, 30'h2ABCDEF3, 32'hA5A55A5A, 4'b1010, 32'h0,        0, 3'b000, 30'h2ABCDEF0, 32'h12345678, 4};
    tbl[3] = '{2, 1'b0, 30'h2,        32'h0,        4'h0,    32'hCAFEF00D, 1, 3'b001, 30'h0,        32'hCAFEF00D, 0};
    tbl[4] = '{1, 1'b1, 30'h10,       32'h0,        4'hF,    32'h0,        0, 3'b000, 30'h10,       32'hCAFEF00D, 4};
    tbl[5] = '{0, 1'b0, 30'h3FFFFFFE, 32'h0,        4'h0,    32'hFFFFFFFF, 3, 3'b001, 30'h3FFFFFFC, 32'hFFFFFFFF, 0};

    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req_done", 32'(req_done), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    rst_n = 1'b1;
    calib_done = 1'b1;
    step();

    for (int v = 0; v < 6; v++) run_vec(tbl[v]);

    // Command FIFO full for 20 cycles while a write sits in WR_CMD.
    exp_q.push_back('{0, 1'b1, 3'b000, 30'h200, 32'h0BADF00D, 4'b0001, 32'hFFFFFFFF});
    set_req(0, 1'b1, 30'h200, 32'h0BADF00D, 4'b0001);
    mem_cmd_full = 1'b1;
    req[0] = 1'b1;
    repeat (20) step();
    check("stall_busy", {31'd0, busy}, 32'd1);
    mem_cmd_full = 1'b0;
    #1;
    check("stall_release_cmd_en", {31'd0, mem_cmd_en}, 32'd1);
    n = 0;
    do begin
      step();
      n++;
    end while (!req_done[0] && n < 50);
    check("stall_done_latency", 32'(n), 32'd2);
    req[0] = 1'b0;
    step();
    step();

    // Underrun sets the sticky error flag.
    check("err_before_underrun", {31'd0, err}, 32'd0);
    mem_wr_underrun = 1'b1;
    step();
    mem_wr_underrun = 1'b0;
    check("err_after_underrun", {31'd0, err}, 32'd1);
    repeat (3) step();
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset while stuck in WR_WAIT abandons the write without a done pulse.
    hold_wr_busy = 1'b1;
    exp_q.push_back('{2, 1'b1, 3'b000, 30'h40, 32'h13579BDF, 4'h0, 32'hFFFFFFFF});
    set_req(2, 1'b1, 30'h40, 32'h13579BDF, 4'h0);
    req[2] = 1'b1;
    repeat (5) step();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    calib_done = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_rd_data", rd_data, 32'd0);
    check("abort_req_done", 32'(req_done), 32'd0);
    check("abort_wr_data", mem_wr_data, 32'd0);
    check("abort_cmd_addr", 32'(mem_cmd_byte_addr), 32'd0);
    exp_q.delete();
    req = '0;
    hold_wr_busy = 1'b0;
    step();
    check("abort_no_done", 32'(req_done), 32'd0);
    step();
    rst_n = 1'b1;

    // All three requesters held: calib low blocks, then strict rotation 0,1,2,0,1,2.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 30'h1000 + 30'(i * 4), 32'hF0000000 + 32'(i), 4'(i));
    req = '1;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy) busy_seen++;
    end
    check("calib_low_blocks_grant", 32'(busy_seen), 32'd0);
    for (int r = 0; r < 6; r++) begin
      exp_q.push_back('{r % 3, 1'b1, 3'b000, 30'h1000 + 30'((r % 3) * 4),
                        32'hF0000000 + 32'(r % 3), 4'(r % 3), 32'h0});
    end
    calib_done = 1'b1;
    dones = 0;
    n = 0;
    while (dones < 6 && n < 300) begin
      step();
      n++;
      if (req_done != '0) dones++;
    end
    req = '0;
    check("rr_done_count", 32'(dones), 32'd6);
    step();
    step();
    check("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // Stuck read on the TIMEOUT=15 instance: abort 15 cycles after entering RD_WAIT.
    t_req = 3'b001;
    n = 0;
    do begin
      step();
      n++;
      if (n == 10) check("tmo_err_early", {31'd0, t_err}, 32'd0);
    end while (!t_done[0] && n < 100);
    check("tmo_done_cycle", 32'(n), 32'd17);
    check("tmo_err_set", {31'd0, t_err}, 32'd1);
    check("tmo_rd_data_unchanged", t_rd_data, 32'd0);
    t_req = '0;
    repeat (5) step();
    check("tmo_err_sticky", {31'd0, t_err}, 32'd1);
    check("tmo_idle_after", {31'd0, t_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
